data_ram_resp: RTL and testbench
================================

Name: data_ram_resp

Overview:
- Responder at the far end of the core's data-memory port (`ram_ce/ram_we/ram_addr/ram_sel/ram_data`).
- Provides word-organised data RAM with per-byte write lanes, plus a small MMIO window holding a free-running counter, a compare/match interrupt and a sticky decode-error trap.
- Read data returns combinationally in the same cycle as the request, because the core's MEM stage has no wait-state handshake.
- Writes commit at the clock edge.

Parameters:
- DEPTH_LOG2, 12, log2 of RAM depth in 32-bit words (4096 words = 16 KB).
- MMIO_BASE, 16'hFFFF, value of addr_i[31:16] that selects the MMIO window.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- ce_i  input  1  access request, valid for this cycle only.
- we_i  input  1  1 = write, 0 = read; ignored when ce_i = 0.
- addr_i  input  32  byte address; bits [1:0] ignored.
- sel_i  input  4  byte lanes; sel_i[k] selects data_i/data_o bits [8k+7:8k].
- data_i  input  32  write data.
- data_o  output  32  read data, combinational.
- irq_o  output  1  timer match interrupt; equals STATUS.MATCH.
- err_o  output  1  sticky decode error; equals STATUS.ERR.

Behaviour:
- Decode:
  - RAM region: addr_i[31:DEPTH_LOG2+2] == 0; word index = addr_i[DEPTH_LOG2+1:2].
  - MMIO region: addr_i[31:16] == MMIO_BASE; register = addr_i[3:2]; addr_i[15:4] != 0 counts as unmapped.
  - Anything else is unmapped.
- Reset values: COUNT = 0, COMPARE = 0, STATUS = 0, ERRADDR = 0, irq_o = 0, err_o = 0. RAM contents are not reset. data_o = 0 while rst = 1.
- Reads (ce_i & ~we_i):
  - data_o = full selected word, same cycle, zero latency; sel_i does not mask read data.
  - When ce_i = 0, or the read is a write or unmapped, data_o = 0.
- Write-then-read ordering:
  - A write in cycle N is visible to a read in cycle N+1.
  - A read of the same word in cycle N returns the old value; no internal bypass.
- RAM writes (ce_i & we_i): at the edge, each lane k with sel_i[k] = 1 is updated from data_i[8k+7:8k]; other lanes are kept. sel_i = 0 is a no-op.
- MMIO registers, by word offset:
  - 0x0 COUNT: read-only. Increments every cycle not in reset and wraps FFFF_FFFF -> 0. Writes are ignored.
  - 0x4 COMPARE: read/write.
  - 0x8 STATUS: bit0 MATCH, bit1 ERR, other bits read 0. Writing 1 to a bit clears it (W1C).
  - 0xC ERRADDR: read-only; holds addr_i of the first unmapped access since ERR was last clear.
- MMIO write rule: a write takes effect only when sel_i == 4'b1111. Partial-lane MMIO writes are silently dropped and do not set ERR.
- MATCH:
  - Sets at the edge where COUNT == COMPARE and COMPARE != 0.
  - If a set and a W1C hit in the same cycle, the set wins (bit stays 1).
- ERR:
  - Any ce_i access (read or write) to an unmapped address sets ERR at the edge.
  - ERRADDR is captured only if ERR was 0 before that edge.
  - If a set and a W1C hit in the same cycle, the set wins and ERRADDR is recaptured.
  - An unmapped write changes no state other than ERR and ERRADDR.
- Reset mid-operation: any write presented in the reset cycle is discarded, including RAM writes.

Optional Feature:
- Macro DATA_RAM_TIMER_EN.
- Defined: COUNT, COMPARE and MATCH behave as specified above.
- Undefined:
  - COUNT/COMPARE logic is not built; offsets 0x0 and 0x4 read 0 and writes to them are ignored.
  - MATCH is constant 0 and irq_o is tied 0.
  - Offsets 0x0 and 0x4 remain mapped and do not raise ERR.
  - ERR and ERRADDR logic is unaffected.

Decomposition:
- Shared defines file holds: MMIO register offsets (COUNT, COMPARE, STATUS, ERRADDR), STATUS bit indices, and the full-word lane constant 4'b1111.
- Natural sub-module: data_ram_array, the byte-lane-writable storage with combinational read port.
- Decode, MMIO registers and status logic stay in the top.

Test Plan:
- Lane write: write addr 0x10, data 0x11223344, sel 1111; then write 0xAABBCCDD with sel 0101; read 0x10 -> 0x11BB33DD.
- Read/write ordering: in one cycle, write 0xDEADBEEF to 0x20 while reading 0x20 -> old value; next-cycle read -> 0xDEADBEEF.
- Timer (macro defined): after reset, write COMPARE (0xFFFF0004) = 5 -> irq_o rises at the edge where COUNT == 5. Write STATUS = 0x1 -> irq_o = 0 next cycle.
- Set beats clear: arrange the STATUS W1C of MATCH in the same cycle that COUNT == COMPARE -> irq_o stays 1.
- Decode error: read 0x00100000 (DEPTH_LOG2 = 12) -> data_o = 0; err_o = 1 next cycle; ERRADDR = 0x00100000. A second bad access at 0x80000000 leaves ERRADDR unchanged. A W1C on ERR then clears err_o.
- Partial MMIO write and mid-write reset:
  - Write COMPARE with sel 0011 -> COMPARE unchanged and err_o = 0.
  - Assert rst together with a RAM write to 0x40 -> word unchanged; all MMIO registers read 0.

Source files
------------

// File: rtl/data_ram_resp_pkg.sv
// Shared definitions for the data-memory responder: MMIO register offsets,
// STATUS bit positions, the full-word lane mask and a byte-lane merge helper.
package data_ram_resp_pkg;

  // MMIO register selected by addr_i[3:2].
  // Byte offsets: COUNT 0x0, COMPARE 0x4, STATUS 0x8, ERRADDR 0xC.
  typedef enum logic [1:0] {
    REG_COUNT   = 2'd0,
    REG_COMPARE = 2'd1,
    REG_STATUS  = 2'd2,
    REG_ERRADDR = 2'd3
  } mmio_reg_e;

  // STATUS register bit positions.
  localparam int STATUS_MATCH_BIT = 0;
  localparam int STATUS_ERR_BIT   = 1;

  // All four byte lanes enabled; the only lane mask that writes MMIO.
  localparam logic [3:0] SEL_FULL = 4'b1111;

  // Replace the byte lanes flagged in sel of old_word with those of new_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// Word-organised storage with per-byte write lanes and a combinational
// (zero-latency) read port. Writes commit at the rising clock edge, so a
// read of the word being written still sees the old contents this cycle.
module data_ram_array
  import data_ram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [3:0]            sel,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

  // Byte-lane write; lanes with sel[k] = 0 keep their previous contents.
  // NOTE: the array has no reset branch so it maps onto plain RAM macros;
  // software must initialise any word it reads.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= merge_lanes(mem[addr], wdata, sel);
  end

  // Asynchronous read: the core's MEM stage has no wait-state handshake.
  assign rdata = mem[addr];

endmodule

// File: rtl/data_ram_resp.sv
// Data-memory port responder: byte-lane RAM plus an MMIO window holding a
// free-running counter with compare/match interrupt and a sticky
// decode-error trap with captured address.
// Optional feature: define DATA_RAM_TIMER_EN to build COUNT, COMPARE and
// MATCH. Without it those offsets stay mapped but read 0 and irq_o is 0.
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [15:0] MMIO_BASE  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        irq_o,
  output logic        err_o
);

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic      ram_hit;
  logic      mmio_hit;
  logic      unmapped;
  mmio_reg_e reg_sel;

  assign ram_hit  = (addr_i[31:DEPTH_LOG2+2] == '0);
  assign mmio_hit = (addr_i[31:16] == MMIO_BASE) && (addr_i[15:4] == '0);
  assign unmapped = ~ram_hit & ~mmio_hit;
  assign reg_sel  = mmio_reg_e'(addr_i[3:2]);

  // ---------------------------------------------------------------------
  // Access strobes. Anything presented during reset is discarded.
  // ---------------------------------------------------------------------
  logic rd_req;
  logic wr_req;
  logic ram_we;
  logic mmio_wr;
  logic err_set;
  logic clr_err;

  assign rd_req  = ce_i & ~we_i & ~rst;
  assign wr_req  = ce_i &  we_i & ~rst;
  assign ram_we  = wr_req & ram_hit;
  // Partial-lane MMIO writes are dropped silently.
  assign mmio_wr = wr_req & mmio_hit & (sel_i == SEL_FULL);
  assign err_set = ce_i & unmapped;
  assign clr_err = mmio_wr && (reg_sel == REG_STATUS) && data_i[STATUS_ERR_BIT];

  // ---------------------------------------------------------------------
  // RAM storage
  // ---------------------------------------------------------------------
  logic [31:0] ram_rdata;

  data_ram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (addr_i[DEPTH_LOG2+1:2]),
    .sel  (sel_i),
    .wdata(data_i),
    .rdata(ram_rdata)
  );

  // ---------------------------------------------------------------------
  // Timer: COUNT, COMPARE, MATCH
  // ---------------------------------------------------------------------
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        match_q;

`ifdef DATA_RAM_TIMER_EN
  logic match_set;
  logic clr_match;

  assign match_set = (count_q == compare_q) && (compare_q != '0);
  assign clr_match = mmio_wr && (reg_sel == REG_STATUS) && data_i[STATUS_MATCH_BIT];

  // Free-running counter, wraps naturally at 32 bits; writes are ignored.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_q + 32'd1;
  end

  // COMPARE is a plain full-word read/write register.
  always_ff @(posedge clk) begin
    if (rst)                                     compare_q <= '0;
    else if (mmio_wr && reg_sel == REG_COMPARE)  compare_q <= data_i;
  end

  // MATCH is sticky; a set in the same cycle as a W1C wins.
  always_ff @(posedge clk) begin
    if (rst)            match_q <= 1'b0;
    else if (match_set) match_q <= 1'b1;
    else if (clr_match) match_q <= 1'b0;
  end
`else
  assign count_q   = '0;
  assign compare_q = '0;
  assign match_q   = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Decode-error trap: ERR and ERRADDR
  // ---------------------------------------------------------------------
  logic        err_q;
  logic [31:0] erraddr_q;

  // ERRADDR holds the first bad address since ERR was last clear; a set
  // coinciding with a W1C wins and recaptures the address.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      erraddr_q <= '0;
    end else begin
      if (err_set)      err_q <= 1'b1;
      else if (clr_err) err_q <= 1'b0;
      if (err_set && (!err_q || clr_err)) erraddr_q <= addr_i;
    end
  end

  // ---------------------------------------------------------------------
  // Read data mux: full word, no lane masking, zero when not a good read.
  // ---------------------------------------------------------------------
  // NOTE: rdata gets its default before any branch so the mux cannot infer a latch.
  logic [31:0] rdata;
  logic [31:0] status_word;

  // Combinational read path for RAM and MMIO.
  always_comb begin
    rdata                         = '0;
    status_word                   = '0;
    status_word[STATUS_MATCH_BIT] = match_q;
    status_word[STATUS_ERR_BIT]   = err_q;
    if (rd_req) begin
      if (ram_hit) begin
        rdata = ram_rdata;
      end else if (mmio_hit) begin
        case (reg_sel)
          REG_COUNT:   rdata = count_q;
          REG_COMPARE: rdata = compare_q;
          REG_STATUS:  rdata = status_word;
          REG_ERRADDR: rdata = erraddr_q;
          default:     rdata = '0;
        endcase
      end
    end
  end

  assign data_o = rdata;
  assign irq_o  = match_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench for data_ram_resp. A behavioural model (byte map,
// counters, sticky bits) predicts data_o, irq_o and err_o every cycle;
// directed scenarios add explicit expectations on top of the model.
module tb_data_ram_resp;

  localparam int DEPTH_LOG2 = 12;
`ifdef DATA_RAM_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif
  localparam logic [31:0] A_COUNT   = 32'hFFFF_0000;
  localparam logic [31:0] A_COMPARE = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS  = 32'hFFFF_0008;
  localparam logic [31:0] A_ERRADDR = 32'hFFFF_000C;
  localparam logic [31:0] RAM_MASK  = ((32'd1 << (DEPTH_LOG2 + 2)) - 32'd1) & ~32'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        irq_o;
  logic        err_o;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_ram_resp #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .MMIO_BASE (16'hFFFF)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ce_i  (ce_i),
    .we_i  (we_i),
    .addr_i(addr_i),
    .sel_i (sel_i),
    .data_i(data_i),
    .data_o(data_o),
    .irq_o (irq_o),
    .err_o (err_o)
  );

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  logic [7:0]  m_ram [int];
  logic [31:0] m_count   = '0;
  logic [31:0] m_compare = '0;
  logic [31:0] m_erraddr = '0;
  logic        m_match   = 1'b0;
  logic        m_err     = 1'b0;

  function automatic bit in_ram(input logic [31:0] a);
    return (a >> (DEPTH_LOG2 + 2)) == 32'd0;
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
    return (a[31:16] == 16'hFFFF) && (a[15:4] == 12'd0);
  endfunction

  task automatic model_read(input bit r, input bit c, input bit w, input logic [31:0] a,
                            output logic [31:0] val, output bit known);
    val   = '0;
    known = 1'b1;
    if (r || !c || w) return;
    if (in_ram(a)) begin
      for (int k = 0; k < 4; k++) begin
        int key;
        key = int'(a & RAM_MASK) + k;
        if (m_ram.exists(key)) val[8*k +: 8] = m_ram[key];
        else                   known = 1'b0;
      end
    end else if (in_mmio(a)) begin
      case (a[3:2])
        2'd0:    val = TIMER_EN ? m_count : 32'd0;
        2'd1:    val = TIMER_EN ? m_compare : 32'd0;
        2'd2:    val = {30'd0, m_err, m_match};
        default: val = m_erraddr;
      endcase
    end
  endtask

  task automatic model_edge(input bit r, input bit c, input bit w, input logic [31:0] a,
                            input logic [3:0] s, input logic [31:0] d);
    bit bad, full, clr_m, clr_e, nmatch;
    if (r) begin
      m_count = '0; m_compare = '0; m_erraddr = '0; m_match = 1'b0; m_err = 1'b0;
      return;
    end
    bad    = c && !in_ram(a) && !in_mmio(a);
    full   = c && w && in_mmio(a) && (s == 4'hF);
    clr_m  = full && (a[3:2] == 2'd2) && d[0];
    clr_e  = full && (a[3:2] == 2'd2) && d[1];
    nmatch = (TIMER_EN && m_count == m_compare && m_compare != 0) ? 1'b1 : (m_match && !clr_m);
    if (bad && (!m_err || clr_e)) m_erraddr = a;
    m_err = bad || (m_err && !clr_e);
    if (TIMER_EN && full && a[3:2] == 2'd1) m_compare = d;
    if (c && w && in_ram(a))
      for (int k = 0; k < 4; k++)
        if (s[k]) m_ram[int'(a & RAM_MASK) + k] = d[8*k +: 8];
    if (TIMER_EN) m_count = m_count + 32'd1;
    m_match = nmatch;
  endtask

  // One bus cycle: drive at negedge, check read data before the edge,
  // advance the model at the edge, check irq/err just after it.
  task automatic cyc(input bit r, input bit c, input bit w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d, output logic [31:0] rd);
    logic [31:0] exp;
    bit          known;
    @(negedge clk);
    rst = r; ce_i = c; we_i = w; addr_i = a; sel_i = s; data_i = d;
    #1;
    rd = data_o;
    model_read(r, c, w, a, exp, known);
    if (known) begin
      n_vec++;
      if (data_o !== exp) begin
        n_bad++;
        $display("FAIL data_o addr=%h got %h expected %h", a, data_o, exp);
      end
    end
    @(posedge clk);
    model_edge(r, c, w, a, s, d);
    #1;
    n_vec++;
    if (irq_o !== m_match) begin
      n_bad++;
      $display("FAIL irq_o addr=%h got %b expected %b", a, irq_o, m_match);
    end
    n_vec++;
    if (err_o !== m_err) begin
      n_bad++;
      $display("FAIL err_o addr=%h got %b expected %b", a, err_o, m_err);
    end
  endtask

  task automatic idle();
    logic [31:0] rd;
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, rd);
  endtask

  task automatic do_reset();
    logic [31:0] rd;
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, rd);
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] rd;
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'($urandom), 1'($urandom), $urandom & 32'hFC, 4'($urandom), $urandom, rd);
    cyc(1'b0, 1'b1, 1'b0, A_COUNT, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL reset_count got %h expected 0", rd); end
    cyc(1'b0, 1'b1, 1'b0, A_COMPARE, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL reset_compare got %h expected 0", rd); end
    cyc(1'b0, 1'b1, 1'b0, A_STATUS, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL reset_status got %h expected 0", rd); end
    cyc(1'b0, 1'b1, 1'b0, A_ERRADDR, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL reset_erraddr got %h expected 0", rd); end
  endtask

  task automatic test_lane_write();
    logic [31:0] rd;
    cyc(1'b0, 1'b1, 1'b1, 32'h10, 4'b1111, 32'h1122_3344, rd);
    cyc(1'b0, 1'b1, 1'b1, 32'h10, 4'b0101, 32'hAABB_CCDD, rd);
    cyc(1'b0, 1'b1, 1'b0, 32'h10, 4'b0001, 32'd0, rd);
    n_vec++;
    if (rd !== 32'h11BB_33DD) begin n_bad++; $display("FAIL lane_write got %h expected 11bb33dd", rd); end
    cyc(1'b0, 1'b1, 1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF, rd);
    cyc(1'b0, 1'b1, 1'b0, 32'h13, 4'b0000, 32'd0, rd);
    n_vec++;
    if (rd !== 32'h11BB_33DD) begin n_bad++; $display("FAIL sel0_noop got %h expected 11bb33dd", rd); end
  endtask

  task automatic test_rw_ordering();
    logic [31:0] rd;
    cyc(1'b0, 1'b1, 1'b1, 32'h20, 4'hF, 32'h0123_4567, rd);
    cyc(1'b0, 1'b1, 1'b0, 32'h20, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'h0123_4567) begin n_bad++; $display("FAIL old_value got %h expected 01234567", rd); end
    cyc(1'b0, 1'b1, 1'b1, 32'h20, 4'hF, 32'hDEAD_BEEF, rd);
    n_vec++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL write_cycle_data got %h expected 0", rd); end
    cyc(1'b0, 1'b1, 1'b0, 32'h20, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL next_cycle_read got %h expected deadbeef", rd); end
  endtask

  task automatic test_timer();
    logic [31:0] rd;
`ifdef DATA_RAM_TIMER_EN
    int          n_idle;
    bit          hit;
    logic [31:0] c;
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, A_COMPARE, 4'hF, 32'd5, rd);
    n_idle = 0;
    hit    = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      idle();
      n_idle++;
      if (irq_o === 1'b1) hit = 1'b1;
    end
    n_vec++;
    if (!hit || n_idle != 5) begin
      n_bad++;
      $display("FAIL irq_rise idle_cycles=%0d expected 5 (seen=%b)", n_idle, hit);
    end
    cyc(1'b0, 1'b1, 1'b1, A_STATUS, 4'hF, 32'h1, rd);
    n_vec++;
    if (irq_o !== 1'b0) begin n_bad++; $display("FAIL irq_w1c got %b expected 0", irq_o); end
    c = m_count + 32'd4;
    cyc(1'b0, 1'b1, 1'b1, A_COMPARE, 4'hF, c, rd);
    cyc(1'b0, 1'b1, 1'b0, A_COMPARE, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== c) begin n_bad++; $display("FAIL compare_rd got %h expected %h", rd, c); end
    for (int i = 0; i < 20 && m_count != c; i++) idle();
    cyc(1'b0, 1'b1, 1'b1, A_STATUS, 4'hF, 32'h1, rd);
    n_vec++;
    if (irq_o !== 1'b1) begin n_bad++; $display("FAIL set_beats_clear got %b expected 1", irq_o); end
    idle();
    n_vec++;
    if (irq_o !== 1'b1) begin n_bad++; $display("FAIL irq_sticky got %b expected 1", irq_o); end
    cyc(1'b0, 1'b1, 1'b1, A_STATUS, 4'hF, 32'h1, rd);
`else
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, A_COUNT, 4'hF, 32'h0000_1234, rd);
    cyc(1'b0, 1'b1, 1'b1, A_COMPARE, 4'hF, 32'd3, rd);
    for (int i = 0; i < 6; i++) idle();
    cyc(1'b0, 1'b1, 1'b0, A_COUNT, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL notimer_count got %h expected 0", rd); end
    cyc(1'b0, 1'b1, 1'b0, A_COMPARE, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL notimer_compare got %h expected 0", rd); end
    n_vec++;
    if (irq_o !== 1'b0 || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL notimer_flags got irq=%b err=%b expected 0 0", irq_o, err_o);
    end
`endif
  endtask

  task automatic test_decode_err();
    logic [31:0] rd;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 32'h0010_0000, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'd0 || err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL bad_read got data=%h err=%b expected 0 1", rd, err_o);
    end
    cyc(1'b0, 1'b1, 1'b0, A_ERRADDR, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'h0010_0000) begin n_bad++; $display("FAIL erraddr_first got %h expected 00100000", rd); end
    cyc(1'b0, 1'b1, 1'b1, 32'h8000_0000, 4'hF, 32'h5555_5555, rd);
    cyc(1'b0, 1'b1, 1'b0, A_ERRADDR, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'h0010_0000) begin n_bad++; $display("FAIL erraddr_held got %h expected 00100000", rd); end
    cyc(1'b0, 1'b1, 1'b1, A_STATUS, 4'hF, 32'h2, rd);
    n_vec++;
    if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_w1c got %b expected 0", err_o); end
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_3FFC, 4'hF, 32'h0BAD_F00D, rd);
    n_vec++;
    if (err_o !== 1'b0) begin n_bad++; $display("FAIL ram_top_mapped got err=%b expected 0", err_o); end
    cyc(1'b0, 1'b1, 1'b0, 32'h0000_4000, 4'hF, 32'd0, rd);
    cyc(1'b0, 1'b1, 1'b0, A_ERRADDR, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'h0000_4000) begin n_bad++; $display("FAIL erraddr_ram_edge got %h expected 00004000", rd); end
    cyc(1'b0, 1'b1, 1'b1, A_STATUS, 4'hF, 32'h2, rd);
    cyc(1'b0, 1'b1, 1'b0, 32'hFFFF_0010, 4'hF, 32'd0, rd);
    cyc(1'b0, 1'b1, 1'b0, A_ERRADDR, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'hFFFF_0010) begin n_bad++; $display("FAIL erraddr_mmio_hole got %h expected ffff0010", rd); end
    cyc(1'b0, 1'b1, 1'b1, A_STATUS, 4'hF, 32'h2, rd);
  endtask

  task automatic test_partial_mmio();
    logic [31:0] rd;
    logic [31:0] exp;
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, A_COMPARE, 4'hF, 32'h0000_0077, rd);
    cyc(1'b0, 1'b1, 1'b1, A_COMPARE, 4'b0011, 32'h0000_FFFF, rd);
    cyc(1'b0, 1'b1, 1'b0, A_COMPARE, 4'hF, 32'd0, rd);
    exp = TIMER_EN ? 32'h0000_0077 : 32'd0;
    n_vec++;
    if (rd !== exp || err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL partial_compare got %h err=%b expected %h err=0", rd, err_o, exp);
    end
    cyc(1'b0, 1'b1, 1'b0, 32'h0040_0000, 4'hF, 32'd0, rd);
    cyc(1'b0, 1'b1, 1'b1, A_STATUS, 4'b0001, 32'h2, rd);
    n_vec++;
    if (err_o !== 1'b1) begin n_bad++; $display("FAIL partial_w1c got err=%b expected 1", err_o); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd;
    cyc(1'b0, 1'b1, 1'b1, 32'h40, 4'hF, 32'hCAFE_F00D, rd);
    cyc(1'b0, 1'b1, 1'b1, A_COMPARE, 4'hF, 32'h0000_1000, rd);
    cyc(1'b1, 1'b1, 1'b1, 32'h40, 4'hF, 32'h0BAD_BEEF, rd);
    cyc(1'b0, 1'b1, 1'b0, A_COUNT, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL midrst_count got %h expected 0", rd); end
    cyc(1'b0, 1'b1, 1'b0, A_COMPARE, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL midrst_compare got %h expected 0", rd); end
    cyc(1'b0, 1'b1, 1'b0, A_STATUS, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL midrst_status got %h expected 0", rd); end
    cyc(1'b0, 1'b1, 1'b0, A_ERRADDR, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'd0) begin n_bad++; $display("FAIL midrst_erraddr got %h expected 0", rd); end
    cyc(1'b0, 1'b1, 1'b0, 32'h40, 4'hF, 32'd0, rd);
    n_vec++;
    if (rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL midrst_ram got %h expected cafef00d", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    bit          r, c, w;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 63) == 0);
      c = ($urandom_range(0, 9) < 8);
      w = 1'($urandom);
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      d = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = $urandom & 32'h0000_00FF;
        5, 6, 7: begin
          a = 32'hFFFF_0000 | (32'($urandom_range(0, 3)) << 2);
          if (a[3:2] == 2'd1 && $urandom_range(0, 1) == 1) d = m_count + 32'($urandom_range(1, 8));
          if (a[3:2] == 2'd2) d = 32'($urandom_range(0, 3));
        end
        default: begin
          a = $urandom;
          if ((a >> (DEPTH_LOG2 + 2)) == 0) a[31] = 1'b1;
        end
      endcase
      cyc(r, c, w, a, s, d, rd);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lane_write();
    test_rw_ordering();
    test_timer();
    test_decode_err();
    test_partial_mmio();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
